// File: rtl/key_cmd_queue_if.sv
// Keypad-event / command-queue signal bundle between keypad_scanner, key_cmd_queue and snake_core.
// master drives key events and pops; slave (the queue) returns the head command and status.
interface key_cmd_queue_if #(
    parameter int DEPTH = 4
) ();
    localparam int CW = $clog2(DEPTH) + 1;

    logic [3:0]    key_val;
    logic          key_pressed;
    logic [1:0]    cur_dir;
    logic          flush;
    // cmd_valid/cmd_pop: an entry is consumed at a clock edge exactly when
    // cmd_valid && cmd_pop are both high; cmd_pop while cmd_valid=0 has no effect.
    logic          cmd_pop;
    logic          cmd_valid;
    logic [1:0]    cmd_dir;
    logic [CW-1:0] cmd_count;
    logic          overflow;

    modport master (
        output key_val, key_pressed, cur_dir, flush, cmd_pop,
        input  cmd_valid, cmd_dir, cmd_count, overflow
    );

    modport slave (
        input  key_val, key_pressed, cur_dir, flush, cmd_pop,
        output cmd_valid, cmd_dir, cmd_count, overflow
    );
endinterface

// File: rtl/key_cmd_queue.sv
// Turns keypad presses into filtered snake direction commands held in a small FIFO.
// Optional KEY_CMD_DROP_CNT_EN adds a saturating drop_cnt of rejected direction events.
module key_cmd_queue #(
    parameter int         DEPTH     = 4,
    parameter logic [3:0] KEY_UP    = 4'h2,
    parameter logic [3:0] KEY_RIGHT = 4'h6,
    parameter logic [3:0] KEY_DOWN  = 4'h8,
    parameter logic [3:0] KEY_LEFT  = 4'h4
) (
    input  logic           clk,
    input  logic           rst_n,
`ifdef KEY_CMD_DROP_CNT_EN
    key_cmd_queue_if.slave q,
    output logic [7:0]     drop_cnt
`else
    key_cmd_queue_if.slave q
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [1:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, head_idx;
    logic [CW-1:0] count_q, count_d;
    logic          kp_q, valid_q, overflow_q;
    logic [1:0]    dir_q, dir_d;

    logic       ev, dec_ok, cand, pop_acc, do_pop, push, drop, ovf_set;
    logic       full, full_block, is_dup, is_rev;
    logic [1:0] dec_dir, ref_dir;

    always_comb begin
        dec_ok  = 1'b1;
        dec_dir = 2'b00;
        case (q.key_val)
            KEY_UP:    dec_dir = 2'b00;
            KEY_RIGHT: dec_dir = 2'b01;
            KEY_DOWN:  dec_dir = 2'b10;
            KEY_LEFT:  dec_dir = 2'b11;
            default:   dec_ok  = 1'b0;
        endcase
    end

    // Filtering compares against the newest queued command so a burst of
    // presses is judged as the snake will actually experience it.
    always_comb begin
        ev         = q.key_pressed & ~kp_q;
        ref_dir    = (count_q != '0) ? mem[wr_ptr - AW'(1)] : q.cur_dir;
        pop_acc    = q.cmd_pop & valid_q;
        full       = (count_q == FULL_CNT);
        full_block = full & ~pop_acc;
        cand       = ev & dec_ok & ~q.flush;
        is_dup     = (dec_dir == ref_dir);
        is_rev     = (dec_dir == (ref_dir ^ 2'b10));
        push       = cand & ~is_dup & ~is_rev & ~full_block;
        drop       = cand & ~push;
        ovf_set    = cand & ~is_dup & ~is_rev & full_block;
        do_pop     = pop_acc & ~q.flush;

        count_d = count_q;
        case ({push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Next head; a slot being written this edge is not in mem yet.
        head_idx = do_pop ? rd_ptr + AW'(1) : rd_ptr;
        if (count_d == '0)
            dir_d = 2'b00;
        else if (push && (head_idx == wr_ptr))
            dir_d = dec_dir;
        else
            dir_d = mem[head_idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kp_q       <= 1'b1;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            dir_q      <= 2'b00;
            overflow_q <= 1'b0;
        end else begin
            kp_q <= q.key_pressed;
            if (q.flush) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                count_q    <= '0;
                valid_q    <= 1'b0;
                dir_q      <= 2'b00;
                overflow_q <= 1'b0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + AW'(1);
                if (do_pop)
                    rd_ptr <= rd_ptr + AW'(1);
                count_q <= count_d;
                valid_q <= (count_d != '0);
                dir_q   <= dir_d;
                if (ovf_set)
                    overflow_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= dec_dir;
    end

`ifdef KEY_CMD_DROP_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            drop_cnt <= 8'h00;
        else if (q.flush)
            drop_cnt <= 8'h00;
        else if (drop && (drop_cnt != 8'hFF))
            drop_cnt <= drop_cnt + 8'h01;
    end
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif

    assign q.cmd_valid = valid_q;
    assign q.cmd_dir   = dir_q;
    assign q.cmd_count = count_q;
    assign q.overflow  = overflow_q;
endmodule

// File: tb/tb_key_cmd_queue.sv
// Directed bench for key_cmd_queue: event detection, filtering, FIFO order, full/flush/reset corners.
module tb_key_cmd_queue;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    logic [1:0] exp_q[$];

    key_cmd_queue_if #(.DEPTH(4)) q ();

`ifdef KEY_CMD_DROP_CNT_EN
    logic [7:0] drop_cnt;
    key_cmd_queue #(.DEPTH(4)) dut (.clk(clk), .rst_n(rst_n), .q(q), .drop_cnt(drop_cnt));
`else
    key_cmd_queue #(.DEPTH(4)) dut (.clk(clk), .rst_n(rst_n), .q(q));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle press; the write lands at the edge that samples the event.
    task automatic press(input logic [3:0] code);
        q.key_val     = code;
        q.key_pressed = 1'b1;
        tick();
        q.key_pressed = 1'b0;
        tick();
    endtask

    task automatic pop_check(input string tag);
        logic [1:0] e;
        e = exp_q.pop_front();
        check_eq(tag, {31'd0, q.cmd_valid}, 32'd1);
        check_eq(tag, {30'd0, q.cmd_dir}, {30'd0, e});
        q.cmd_pop = 1'b1;
        tick();
        q.cmd_pop = 1'b0;
    endtask

    task automatic do_flush();
        q.flush = 1'b1;
        tick();
        q.flush = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        q.key_val     = 4'h2;
        q.key_pressed = 1'b1;
        q.cur_dir     = 2'b01;
        q.flush       = 1'b0;
        q.cmd_pop     = 1'b0;

        // Reset values, then release with the key still held.
        #12;
        check_eq("rst_valid", {31'd0, q.cmd_valid}, 32'd0);
        check_eq("rst_dir", {30'd0, q.cmd_dir}, 32'd0);
        check_eq("rst_count", {29'd0, q.cmd_count}, 32'd0);
        check_eq("rst_ovf", {31'd0, q.overflow}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(); tick(); tick();
        check_eq("held_no_ev_valid", {31'd0, q.cmd_valid}, 32'd0);
        check_eq("held_no_ev_count", {29'd0, q.cmd_count}, 32'd0);
        q.key_pressed = 1'b0;
        tick();

        // Single accepted press and pop.
        q.cur_dir = 2'b01;
        press(4'h2);
        exp_q.push_back(2'b00);
        check_eq("t2_count", {29'd0, q.cmd_count}, 32'd1);
        pop_check("t2_pop");
        check_eq("t2_valid_after", {31'd0, q.cmd_valid}, 32'd0);
        check_eq("t2_dir_after", {30'd0, q.cmd_dir}, 32'd0);

        // Pop on empty queue is ignored; unmapped key ignored.
        q.cmd_pop = 1'b1;
        tick();
        q.cmd_pop = 1'b0;
        check_eq("empty_pop_count", {29'd0, q.cmd_count}, 32'd0);
        press(4'h5);
        check_eq("bad_code_count", {29'd0, q.cmd_count}, 32'd0);

        // Reversal and duplicate rejection.
        press(4'h4);
        press(4'h6);
        check_eq("t3_count", {29'd0, q.cmd_count}, 32'd0);
`ifdef KEY_CMD_DROP_CNT_EN
        check_eq("t3_drop_cnt", {24'd0, drop_cnt}, 32'd2);
`endif

        // Held key produces only one event.
        q.cur_dir     = 2'b11;
        q.key_val     = 4'h2;
        q.key_pressed = 1'b1;
        tick(); tick(); tick();
        q.key_pressed = 1'b0;
        tick();
        check_eq("hold_once_count", {29'd0, q.cmd_count}, 32'd1);
        exp_q.push_back(2'b00);
        pop_check("hold_pop");

        // Fill to DEPTH, overflow on the fifth press, FIFO order.
        press(4'h2); press(4'h6); press(4'h8); press(4'h4);
        exp_q.push_back(2'b00); exp_q.push_back(2'b01);
        exp_q.push_back(2'b10); exp_q.push_back(2'b11);
        check_eq("t4_full_count", {29'd0, q.cmd_count}, 32'd4);
        check_eq("t4_ovf_before", {31'd0, q.overflow}, 32'd0);
        press(4'h2);
        check_eq("t4_count_after", {29'd0, q.cmd_count}, 32'd4);
        check_eq("t4_ovf", {31'd0, q.overflow}, 32'd1);
`ifdef KEY_CMD_DROP_CNT_EN
        check_eq("t4_drop_cnt", {24'd0, drop_cnt}, 32'd3);
`endif
        pop_check("t4_pop0"); pop_check("t4_pop1");
        pop_check("t4_pop2"); pop_check("t4_pop3");
        check_eq("t4_empty", {29'd0, q.cmd_count}, 32'd0);
        check_eq("t4_ovf_sticky", {31'd0, q.overflow}, 32'd1);

        // Flush clears overflow; then full queue with simultaneous push and pop.
        do_flush();
        check_eq("flush_ovf", {31'd0, q.overflow}, 32'd0);
`ifdef KEY_CMD_DROP_CNT_EN
        check_eq("flush_drop_cnt", {24'd0, drop_cnt}, 32'd0);
`endif
        press(4'h2); press(4'h6); press(4'h8); press(4'h4);
        exp_q.push_back(2'b00); exp_q.push_back(2'b01);
        exp_q.push_back(2'b10); exp_q.push_back(2'b11);
        check_eq("t5_head", {30'd0, q.cmd_dir}, 32'd0);
        q.key_val     = 4'h2;
        q.key_pressed = 1'b1;
        q.cmd_pop     = 1'b1;
        tick();
        q.key_pressed = 1'b0;
        q.cmd_pop     = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back(2'b00);
        check_eq("t5_count", {29'd0, q.cmd_count}, 32'd4);
        check_eq("t5_ovf", {31'd0, q.overflow}, 32'd0);
        tick();
        pop_check("t5_pop0"); pop_check("t5_pop1");
        pop_check("t5_pop2"); pop_check("t5_pop3");
        check_eq("t5_empty_valid", {31'd0, q.cmd_valid}, 32'd0);

        // Flush with a simultaneous press at count 3.
        press(4'h2); press(4'h6); press(4'h8);
        check_eq("t6_count3", {29'd0, q.cmd_count}, 32'd3);
        q.key_val     = 4'h4;
        q.key_pressed = 1'b1;
        q.flush       = 1'b1;
        tick();
        q.flush       = 1'b0;
        q.key_pressed = 1'b0;
        exp_q.delete();
        tick();
        check_eq("t6_count", {29'd0, q.cmd_count}, 32'd0);
        check_eq("t6_valid", {31'd0, q.cmd_valid}, 32'd0);
        check_eq("t6_ovf", {31'd0, q.overflow}, 32'd0);
        check_eq("t6_dir", {30'd0, q.cmd_dir}, 32'd0);

        // Asynchronous reset mid-operation.
        press(4'h2);
        check_eq("arst_pre_count", {29'd0, q.cmd_count}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_count", {29'd0, q.cmd_count}, 32'd0);
        check_eq("arst_valid", {31'd0, q.cmd_valid}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
